// File: rtl/noc_pkg.sv
// Shared constants and types for the NoC output-port arbiter.
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int NUM_PORTS = 5;
  localparam int PKT_FLITS = 5;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [2:0]        port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first requester strictly after ptr,
// wrapping modulo NUM_PORTS.
module noc_rr_pick
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_idx_t            ptr,
  output logic [NUM_PORTS-1:0] winner,
  output port_idx_t            winner_idx,
  output logic                 any_req
);

  // Walk from the farthest offset back to the nearest so the closest
  // requester after ptr is the one left standing.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // a combinational output unassigned would infer a latch.
    winner     = '0;
    winner_idx = '0;
    any_req    = |req;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_PORTS]) begin
        winner                                 = '0;
        winner[(int'(ptr) + k) % NUM_PORTS]    = 1'b1;
        winner_idx = port_idx_t'((int'(ptr) + k) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Output-port wormhole arbiter: round-robin grant held for a whole packet.
// Optional completed-packet counter enabled by defining NOC_ARB_PKT_CNT_EN.
module noc_out_arbiter
  import noc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*FLIT_W-1:0] data_i,
  input  logic                        out_ready_i,
  output logic [NUM_PORTS-1:0]        grant_o,
  output logic [NUM_PORTS-1:0]        pop_o,
  output logic                        valid_o,
  output flit_t                       data_o,
  output logic                        last_o,
  output logic                        busy_o
`ifdef NOC_ARB_PKT_CNT_EN
  ,
  output logic [15:0]                 pkt_cnt_o
`endif
);

  arb_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  port_idx_t            idx_q, idx_d;
  port_idx_t            ptr_q, ptr_d;
  logic [2:0]           cnt_q, cnt_d;

  logic [NUM_PORTS-1:0] pick_onehot;
  port_idx_t            pick_idx;
  logic                 pick_any;
  logic                 xfer;
  logic                 last_flit;

  noc_rr_pick u_pick (
    .req        (req_i),
    .ptr        (ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any_req    (pick_any)
  );

  assign xfer      = (state_q == LOCK) && out_ready_i;
  assign last_flit = (state_q == LOCK) && (cnt_q == 3'(PKT_FLITS - 1));

  // State register; ptr resets to the top port so port 0 wins first.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= port_idx_t'(NUM_PORTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; requests are only looked at while idle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          idx_d   = pick_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (xfer) begin
          if (last_flit) begin
            cnt_d   = '0;
            ptr_d   = idx_q;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic; the flit path is a pure mux so it tracks the queue head.
  always_comb begin
    grant_o = grant_q;
    pop_o   = grant_q & {NUM_PORTS{out_ready_i}};
    valid_o = 1'b0;
    busy_o  = 1'b0;
    last_o  = 1'b0;
    data_o  = '0;
    if (state_q == LOCK) begin
      valid_o = 1'b1;
      busy_o  = 1'b1;
      last_o  = last_flit;
      data_o  = data_i[FLIT_W*int'(idx_q) +: FLIT_W];
    end
  end

`ifdef NOC_ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else if (last_flit && out_ready_i && (pkt_cnt_q != 16'hFFFF)) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule
